// File: rtl/encode_stream_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// kyber_enc_pkg
// Shared constants, FSM state type and config-legality helpers for the
// streaming ByteEncode_d packer (encode_stream_ctrl and bit_packer).
// -----------------------------------------------------------------------------
package kyber_enc_pkg;

    localparam int N_COEF   = 256; // coefficients per polynomial
    localparam int MAX_D    = 12;  // widest coefficient field
    localparam int MAX_POLY = 3;   // most polynomials per job
    localparam int ACC_W    = 20;  // 7 residual bits + 12 new bits, rounded up
    localparam int CNT_W    = 11;  // byte counter / job length width (max 1152)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_e;

    function automatic logic legal_d(input logic [3:0] d);
        return (d != 4'd0) && (d <= 4'(MAX_D));
    endfunction

    function automatic logic legal_k(input logic [1:0] k);
        return (k != 2'd0) && (k <= 2'(MAX_POLY));
    endfunction

endpackage

// File: rtl/encode_stream_ctrl_bit_packer.sv
// -----------------------------------------------------------------------------
// bit_packer
// LSB-first bit accumulator. A push appends the low push_width_i bits of
// push_data_i above the bits already held; a pop drops the lowest byte.
// The caller guarantees push only when count_o < 8 and pop only when
// count_o >= 8, so the two never occur together.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   push_i         append a field this cycle
//   push_data_i    field source; bits at and above push_width_i are ignored
//   push_width_i   field width, 1..12
//   pop_i          discard the lowest 8 bits this cycle
//   pop_data_o     lowest 8 bits of the accumulator
//   count_o        number of valid bits held (0..19)
// -----------------------------------------------------------------------------
module bit_packer
    import kyber_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [15:0] push_data_i,
    input  logic [3:0]  push_width_i,
    input  logic        pop_i,
    output logic [7:0]  pop_data_o,
    output logic [4:0]  count_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] push_mask, push_bits;
    logic [4:0]       bit_cnt_q, bit_cnt_d;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        push_mask = (ACC_W'(1) << push_width_i) - ACC_W'(1);
        push_bits = ACC_W'(push_data_i) & push_mask;

        if (push_i) begin
            // bit_cnt_q < 8 on push, so a 12-bit field ends at bit 18 at most
            acc_d     = acc_q | (push_bits << bit_cnt_q);
            bit_cnt_d = bit_cnt_q + {1'b0, push_width_i};
        end else if (pop_i) begin
            acc_d     = acc_q >> 8;
            bit_cnt_d = bit_cnt_q - 5'd8;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign pop_data_o = acc_q[7:0];
    assign count_o    = bit_cnt_q;

endmodule

// File: rtl/encode_stream_ctrl.sv
// -----------------------------------------------------------------------------
// encode_stream_ctrl
// Streaming ByteEncode_d: takes one coefficient per handshake, keeps its low
// D bits and emits the little-endian packed stream as bytes. One job encodes
// K polynomials of 256 coefficients, i.e. K*32*D bytes.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   start, d_sel, num_poly       job request and config (sampled in IDLE)
//   busy, done, err              job status; done/err are one-cycle pulses
//   coef_valid/ready/data        coefficient input stream
//   byte_valid/ready/data/last   packed byte output stream
// -----------------------------------------------------------------------------
module encode_stream_ctrl
    import kyber_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  d_sel,
    input  logic [1:0]  num_poly,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        coef_valid,
    output logic        coef_ready,
    input  logic [15:0] coef_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_last
);

    enc_state_e       state_q, state_d;
    logic [3:0]       d_q, d_d;
    logic [1:0]       k_q, k_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [7:0]       coef_cnt_q, coef_cnt_d;
    logic [1:0]       poly_cnt_q, poly_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             err_q, err_d;

    logic [4:0]       bit_cnt;
    logic             coef_fire, byte_fire;

    bit_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .push_i       (coef_fire),
        .push_data_i  (coef_data),
        .push_width_i (d_q),
        .pop_i        (byte_fire),
        .pop_data_o   (byte_data),
        .count_o      (bit_cnt)
    );

    // Handshakes: coefficient intake only while less than a byte is held,
    // byte output only while at least a byte is held.
    always_comb begin
        coef_ready = (state_q == RUN) && (bit_cnt < 5'd8) && (poly_cnt_q < k_q);
        byte_valid = (state_q == RUN) && (bit_cnt >= 5'd8);
        byte_last  = byte_valid && (byte_cnt_q == total_q - CNT_W'(1));
        coef_fire  = coef_valid && coef_ready;
        byte_fire  = byte_valid && byte_ready;
        busy       = (state_q == RUN);
        done       = (state_q == DONE);
        err        = err_q;
    end

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        k_d        = k_q;
        total_d    = total_q;
        coef_cnt_d = coef_cnt_q;
        poly_cnt_d = poly_cnt_q;
        byte_cnt_d = byte_cnt_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal_d(d_sel) && legal_k(num_poly)) begin
                        state_d    = RUN;
                        d_d        = d_sel;
                        k_d        = num_poly;
                        // 256 coefficients * D bits / 8 = 32*D bytes per poly
                        total_d    = CNT_W'(num_poly) * CNT_W'(d_sel) * CNT_W'(N_COEF / 8);
                        coef_cnt_d = '0;
                        poly_cnt_d = '0;
                        byte_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (coef_fire) begin
                    coef_cnt_d = coef_cnt_q + 8'd1;
                    if (coef_cnt_q == 8'(N_COEF - 1)) begin
                        poly_cnt_d = poly_cnt_q + 2'd1;
                    end
                end
                if (byte_fire) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            d_q        <= '0;
            k_q        <= '0;
            total_q    <= '0;
            coef_cnt_q <= '0;
            poly_cnt_q <= '0;
            byte_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            k_q        <= k_d;
            total_q    <= total_d;
            coef_cnt_q <= coef_cnt_d;
            poly_cnt_q <= poly_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/encode_stream_ctrl.md
Name: encode_stream_ctrl

Overview:
- Sequential controller for ByteEncode_d. It replaces the fully combinational 256-coefficient encode with a streaming packer.
- Accepts one coefficient per handshake, takes its low D bits, and emits the packed little-endian bit stream as bytes over a valid/ready interface.
- Sequences 1..3 polynomials per job (Kyber-768: k=3). Serves the t/u encode (D=12/10) and the v encode (D=4) in the encrypt/decrypt datapaths.

Parameters:
- N_COEF, 256, coefficients per polynomial.
- MAX_D, 12, largest supported bit width per coefficient.
- MAX_POLY, 3, largest polynomial count per job.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- d_sel  in  4  bits per coefficient, legal 1..12; sampled with start.
- num_poly  in  2  polynomial count, legal 1..3; sampled with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  one-cycle pulse when start is rejected for illegal config.
- coef_valid  in  1  coefficient available.
- coef_ready  out  1  coefficient accepted when valid&ready.
- coef_data  in  16  coefficient; only bits [D-1:0] are used.
- byte_valid  out  1  packed byte available.
- byte_ready  in  1  downstream accepts byte.
- byte_data  out  8  packed byte.
- byte_last  out  1  qualifies the final byte of the job.

Behaviour:
- Reset: all outputs 0; acc=0, bit_cnt=0, all counters 0, state=IDLE. Reset mid-job aborts with no done and no partial byte.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start with d_sel in 1..12 and num_poly in 1..3 latches D and K, then goes to RUN; busy rises next cycle.
  - Illegal config: err pulses next cycle, FSM stays IDLE.
  - start in RUN or DONE is ignored.
- Accumulator acc is 20 bits (7 residual + 12 new). bit_cnt is 0..19.
- coef_ready = (state==RUN) & (bit_cnt<8) & coefficients remain in the job.
- On coef fire: acc |= (coef_data & ((1<<D)-1)) << bit_cnt; bit_cnt += D; coef_cnt++. Coefficient bit j lands at stream bit i*D+j, LSB first.
- byte_valid = (state==RUN) & (bit_cnt>=8); byte_data = acc[7:0].
- On byte fire: acc >>= 8; bit_cnt -= 8; byte_cnt++.
- Coef fire and byte fire are mutually exclusive by construction (bit_cnt<8 versus >=8). No simultaneous update path exists.
- coef_cnt wraps 255->0 and increments poly_cnt. After K*256 coefficients, coef_ready stays 0.
- Job ends when byte_cnt == K*32*D. 256*D is always a multiple of 8, so no flush or padding is needed and bit_cnt==0 at the end.
- byte_last = byte_valid & (byte_cnt == K*32*D-1).
- The last byte fire moves the FSM to DONE. done pulses for one cycle, busy falls in the same cycle, and the FSM returns to IDLE next cycle.
- Backpressure: byte_ready low holds byte_data and byte_valid stable. coef_ready stays 0 while bit_cnt>=8.
- Latency: the first byte can appear 1 cycle after the first coef fire when D>=8. For D<8, it appears after ceil(8/D) coefficients.
- Throughput: one handshake per cycle of either kind.
- Width rules:
  - byte_cnt is 11 bits (max 3*384 = 1152).
  - Products K*32*D are computed once at start into a registered 11-bit total.

Decomposition:
- Package kyber_enc_pkg holds: N_COEF, MAX_D, MAX_POLY, ACC_W=20; typedef enum {IDLE, RUN, DONE} enc_state_e; function legal_d(d).
- Sub-module bit_packer: owns acc and bit_cnt. Interfaces are push(data, width), pop (8 bits), and count. The controller holds the FSM, counters and handshakes.

Test Plan:
- D=12, K=1: coef[0]=0xABC, coef[1]=0x123, rest 0 -> bytes 0 to 2 = 0xBC, 0x3A, 0x12; 384 bytes total; byte_last on byte 383; done 1 cycle after.
- D=1, K=1, all coef=0xFFFF -> 32 bytes, all 0xFF; upper coefficient bits masked.
- D=4, K=3, coef[i]=i&0xF -> 384 bytes with byte n = ((2n+1)&0xF)<<4 | (2n&0xF); byte_last only on byte 383; done once.
- Random byte_ready (50%) with D=10, K=3 -> stream equals the reference model. Data stays stable while stalled. coef_ready is never high while bit_cnt>=8.
- d_sel=13 or num_poly=0 with start -> err pulse, busy stays 0, no bytes. A start during RUN is ignored.
- rst asserted after byte 50 of a D=12 job -> all outputs 0 immediately. A new start with D=4, K=1 then produces a correct 128-byte stream.
